// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release sequencer
// Optional macro PLL_SEQ_LOCK_LOSS_CNT_EN adds the saturating lock_loss_count output.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic [3:0] retry_count
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_rst_q, sys_reset_n_q, seq_ready_q, seq_fail_q;

  // One shared dwell counter: only one of pulse, timeout or stable timing is live per state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            if (retry_q < 4'(MAX_RETRIES)) begin
              state_d = RESET_PLL;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = FAIL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE: begin
          // Lock loss wins over a completing stable count.
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s_q) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        FAIL:    state_d = FAIL;
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      seq_ready_q   <= 1'b0;
      seq_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      pll_rst_q     <= (state_d == RESET_PLL);
      sys_reset_n_q <= (state_d == RUN);
      seq_ready_q   <= (state_d == RUN);
      seq_fail_q    <= (state_d == FAIL);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign seq_ready   = seq_ready_q;
  assign seq_fail    = seq_fail_q;
  assign retry_count = retry_q;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_count_q, lock_loss_count_d;

  always_comb begin
    lock_loss_count_d = lock_loss_count_q;
    if (!restart && state_q == RUN && !lock_s_q && lock_loss_count_q != 8'hff)
      lock_loss_count_d = lock_loss_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) lock_loss_count_q <= 8'd0;
    else          lock_loss_count_q <= lock_loss_count_d;
  end

  assign lock_loss_count = lock_loss_count_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer with a behavioural sequence model
// Works with or without PLL_SEQ_LOCK_LOSS_CNT_EN defined.
module tb_pll_reset_sequencer;
  localparam int R  = 4;
  localparam int S  = 8;
  localparam int T  = 32;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, restart;
  logic       pll_rst, sys_reset_n, seq_ready, seq_fail;
  logic [3:0] retry_count;
  logic [7:0] loss_act;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_count;
  assign loss_act = lock_loss_count;
`else
  assign loss_act = 8'd0;
`endif

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(R), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .seq_ready(seq_ready),
    .seq_fail(seq_fail), .retry_count(retry_count)
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    , .lock_loss_count(lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: phases of the sequence and elapsed time per phase, stepped per clock.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_RUN = 3, PH_DEAD = 4;
  int   phase = PH_PULSE, elapsed = 0, tries = 0, losses = 0;
  logic sync1 = 1'b0, sync2 = 1'b0;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    logic seen;
    if (!reset_n) begin
      phase = PH_PULSE; elapsed = 0; tries = 0; losses = 0;
      sync1 = 1'b0; sync2 = 1'b0;
    end else begin
      seen = sync2;
      sync2 = sync1;
      sync1 = pll_locked;
      if (restart) begin
        phase = PH_PULSE; elapsed = 0; tries = 0;
      end else if (phase == PH_PULSE) begin
        elapsed++;
        if (elapsed == R) begin phase = PH_WAIT; elapsed = 0; end
      end else if (phase == PH_WAIT) begin
        if (seen) begin
          phase = PH_SETTLE; elapsed = 0;
        end else begin
          elapsed++;
          if (elapsed == T) begin
            elapsed = 0;
            if (tries < MR) begin tries++; phase = PH_PULSE; end
            else phase = PH_DEAD;
          end
        end
      end else if (phase == PH_SETTLE) begin
        if (!seen) begin
          phase = PH_WAIT; elapsed = 0;
        end else begin
          elapsed++;
          if (elapsed == S) phase = PH_RUN;
        end
      end else if (phase == PH_RUN) begin
        if (!seen) begin
          phase = PH_PULSE; elapsed = 0; tries = 0;
          if (losses < 255) losses++;
        end
      end
    end
    exp_q.push_back({phase == PH_PULSE, phase == PH_RUN, phase == PH_RUN, phase == PH_DEAD,
                     4'(tries),
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
                     8'(losses)});
`else
                     8'd0});
`endif
  end

  always @(negedge clk) begin
    logic [15:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pll_rst, sys_reset_n, seq_ready, seq_fail, retry_count, loss_act};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got %h expected %h (rst,sysn,rdy,fail,retry,loss)", $time, a, e);
      end
    end
  end

  task automatic measure_seq(output int pulse, output int lat);
    pulse = 0;
    while (pll_rst && pulse < 100) begin pulse++; @(negedge clk); end
    lat = pulse;
    while (!sys_reset_n && lat < 200) begin lat++; @(negedge clk); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulse, lat, n, len;
    logic lvl, rst_seen;
    reset_n = 1'b0; restart = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);

    // Power-up with lock already present.
    reset_n = 1'b1;
    measure_seq(pulse, lat);
    check("powerup_pulse_len", pulse, R);
    check_range("powerup_ready_latency", lat, R + S, R + S + 4);
    check("powerup_seq_ready", seq_ready, 1);

    // No lock at all: three attempts, then FAIL.
    pll_locked = 1'b0; restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    n = 0;
    while (!seq_fail && n < 300) begin @(negedge clk); n++; end
    check("fail_after_timeouts", n, (MR + 1) * (R + T));
    check("fail_retry_count", retry_count, MR);
    check("fail_pll_rst_low", pll_rst, 0);
    repeat (5) @(negedge clk);
    check("fail_held", seq_fail, 1);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("restart_pll_rst", pll_rst, 1);
    check("restart_retry_clear", retry_count, 0);
    check("restart_fail_clear", seq_fail, 0);

    // Lock glitch during STABLE returns to WAIT_LOCK without a new pulse.
    n = 0;
    while (pll_rst && n < 50) begin @(negedge clk); n++; end
    rst_seen = 1'b0;
    pll_locked = 1'b1;
    repeat (7) begin @(negedge clk); rst_seen |= pll_rst; end
    pll_locked = 1'b0;
    @(negedge clk); rst_seen |= pll_rst;
    pll_locked = 1'b1;
    repeat (30) begin @(negedge clk); rst_seen |= pll_rst; end
    check("stable_glitch_no_pulse", rst_seen, 0);
    check("stable_glitch_then_run", sys_reset_n, 1);

    // One-cycle lock loss while running.
    pll_locked = 1'b0; n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) pll_locked = 1'b1;
    end while (sys_reset_n && n < 50);
    check_range("run_loss_sysrst_latency", n, 1, 4);
    measure_seq(pulse, lat);
    check("run_loss_pulse_len", pulse, R);
    check_range("run_loss_relock_latency", lat, R + S, R + S + 4);
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    check("lock_loss_count_one", lock_loss_count, 1);
`endif

    // One-cycle reset in RUN.
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check("reset_in_run_sysn", sys_reset_n, 0);
    check("reset_in_run_pll_rst", pll_rst, 1);
    measure_seq(pulse, lat);
    check("rerun_pulse_len", pulse, R);
    check_range("rerun_ready_latency", lat, R + S, R + S + 4);
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    check("lock_loss_count_reset", lock_loss_count, 0);
`endif

    // Randomized lock behaviour with sparse restarts and resets.
    n = 0;
    while (n < 2000) begin
      len = $urandom_range(1, 50);
      lvl = ($urandom_range(0, 3) != 0);
      repeat (len) begin
        @(negedge clk);
        pll_locked = lvl;
        restart = ($urandom_range(0, 199) == 0);
        reset_n = ($urandom_range(0, 499) != 0);
      end
      n += len;
    end
    @(negedge clk);
    restart = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
